// File: rtl/mem_access_stage.sv
`default_nettype none
// mem_access_stage: load/store unit between execute and writeback, 3-state FSM (IDLE/REQ/WAIT).
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module mem_access_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [DATA_WIDTH-1:0] ex_addr,
    input  logic [DATA_WIDTH-1:0] ex_wdata,
    input  logic [2:0]            ex_funct3,
    input  logic                  ex_load,
    input  logic                  ex_store,
    input  logic                  ex_regwrite,
    input  logic [4:0]            ex_rd,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DATA_WIDTH-1:0] dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic                  dmem_gnt,
    input  logic                  dmem_rvalid,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  wb_valid,
    output logic                  wb_regwrite,
    output logic [4:0]            wb_rd,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  misalign
);

`ifdef LSU_MISALIGN_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t                state;
    logic                  misalign_q;
    logic                  pend_store;
    logic                  pend_regwrite;
    logic [4:0]            pend_rd;
    logic [2:0]            ld_funct3;
    logic [1:0]            ld_off;

    logic                  mem_op;
    logic                  misaligned;
    logic                  trap;
    logic [1:0]            lane_off;
    logic [3:0]            lane_be;
    logic [DATA_WIDTH-1:0] lane_wdata;
    logic [7:0]            load_byte;
    logic [15:0]           load_half;
    logic [DATA_WIDTH-1:0] load_ext;

    assign mem_op   = ex_load | ex_store;
    assign trap     = TRAP_EN & misaligned;
    assign misalign = TRAP_EN ? misalign_q : 1'b0;

    // Without the trap, offending low address bits are forced to zero here.
    always_comb begin
        misaligned = 1'b0;
        lane_off   = 2'b00;
        lane_be    = 4'b1111;
        lane_wdata = ex_wdata;
        case (ex_funct3[1:0])
            2'b00: begin
                lane_off   = ex_addr[1:0];
                lane_be    = 4'b0001 << lane_off;
                lane_wdata = {(DATA_WIDTH/8){ex_wdata[7:0]}};
            end
            2'b01: begin
                misaligned = ex_addr[0];
                lane_off   = {ex_addr[1], 1'b0};
                lane_be    = 4'b0011 << lane_off;
                lane_wdata = {(DATA_WIDTH/16){ex_wdata[15:0]}};
            end
            default: begin
                misaligned = |ex_addr[1:0];
                lane_off   = 2'b00;
                lane_be    = 4'b1111;
                lane_wdata = ex_wdata;
            end
        endcase
    end

    always_comb begin
        load_byte = dmem_rdata[{ld_off, 3'b000} +: 8];
        load_half = dmem_rdata[{ld_off[1], 4'b0000} +: 16];
        case (ld_funct3)
            3'b000:  load_ext = {{(DATA_WIDTH-8){load_byte[7]}}, load_byte};
            3'b001:  load_ext = {{(DATA_WIDTH-16){load_half[15]}}, load_half};
            3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, load_byte};
            3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, load_half};
            default: load_ext = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            ex_ready      <= 1'b1;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_be       <= 4'b0000;
            dmem_wdata    <= '0;
            wb_valid      <= 1'b0;
            wb_regwrite   <= 1'b0;
            wb_rd         <= 5'd0;
            wb_data       <= '0;
            misalign_q    <= 1'b0;
            pend_store    <= 1'b0;
            pend_regwrite <= 1'b0;
            pend_rd       <= 5'd0;
            ld_funct3     <= 3'b000;
            ld_off        <= 2'b00;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (ex_valid) begin
                        if (!mem_op) begin
                            wb_valid    <= 1'b1;
                            wb_regwrite <= ex_regwrite;
                            wb_rd       <= ex_rd;
                            wb_data     <= ex_addr;
                            misalign_q  <= 1'b0;
                        end else if (trap) begin
                            wb_valid    <= 1'b1;
                            wb_regwrite <= 1'b0;
                            wb_rd       <= ex_rd;
                            wb_data     <= ex_addr;
                            misalign_q  <= 1'b1;
                        end else begin
                            // A set ex_load wins over ex_store.
                            dmem_req      <= 1'b1;
                            dmem_we       <= ~ex_load;
                            dmem_addr     <= {ex_addr[DATA_WIDTH-1:2], 2'b00};
                            dmem_be       <= lane_be;
                            dmem_wdata    <= ex_load ? '0 : lane_wdata;
                            pend_store    <= ~ex_load;
                            pend_regwrite <= ex_regwrite;
                            pend_rd       <= ex_rd;
                            ld_funct3     <= ex_funct3;
                            ld_off        <= lane_off;
                            ex_ready      <= 1'b0;
                            state         <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (pend_store) begin
                            wb_valid    <= 1'b1;
                            wb_regwrite <= 1'b0;
                            wb_rd       <= pend_rd;
                            wb_data     <= '0;
                            misalign_q  <= 1'b0;
                            ex_ready    <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_rvalid) begin
                        wb_valid    <= 1'b1;
                        wb_regwrite <= pend_regwrite;
                        wb_rd       <= pend_rd;
                        wb_data     <= load_ext;
                        misalign_q  <= 1'b0;
                        ex_ready    <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    ex_ready <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter DATA_WIDTH SHALL default to 32 and set the width of the address and data paths.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 ex_valid  input  1  execute stage presents an instruction.
REQ-005 ex_ready  output  1  stage accepts the instruction this cycle.
REQ-006 ex_addr  input  32  ALU result: effective address, or pass-through result for non-memory instructions.
REQ-007 ex_wdata  input  32  store data (rs2).
REQ-008 ex_funct3  input  3  access size and signedness.
REQ-009 ex_load / ex_store / ex_regwrite  input  1 each  instruction class and writeback enable.
REQ-010 ex_rd  input  5  destination register.
REQ-011 dmem_req, dmem_we  output  1 each  memory request and write enable.
REQ-012 dmem_addr  output  32  word-aligned address, with bits [1:0] always 0.
REQ-013 dmem_be  output  4  byte enables.
REQ-014 dmem_wdata  output  32  lane-aligned store data.
REQ-015 dmem_gnt, dmem_rvalid  input  1 each  request accepted; read data valid.
REQ-016 dmem_rdata  input  32  read data.
REQ-017 wb_valid, wb_regwrite  output  1 each  one-cycle writeback pulse; register write enable.
REQ-018 wb_rd  output  5  writeback destination.
REQ-019 wb_data  output  32  writeback data.
REQ-020 misalign  output  1  misaligned-access flag, valid with wb_valid.

Function
REQ-021 FSM states SHALL be IDLE, REQ and WAIT; ex_ready SHALL be 1 only in IDLE.
REQ-022 Non-memory accept (neither ex_load nor ex_store): wb_valid SHALL be 1 the next cycle with wb_data=ex_addr and wb_regwrite=ex_regwrite; the FSM stays in IDLE (latency 1, one instruction per cycle).
REQ-023 Load or store accept SHALL go IDLE->REQ; dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata SHALL be registered and held stable until dmem_gnt.
REQ-024 REQ with dmem_gnt: a store SHALL return to IDLE and emit wb_valid the next cycle with wb_regwrite=0; a load SHALL go to WAIT.
REQ-025 dmem_req SHALL drop in the cycle after dmem_gnt.
REQ-026 WAIT with dmem_rvalid: the load SHALL be extracted and extended, the FSM returns to IDLE, and wb_valid fires the next cycle.
REQ-027 dmem_rvalid SHALL be ignored outside WAIT, and dmem_gnt SHALL be ignored outside REQ.
REQ-028 Size mapping:
- funct3[1:0] 00 is byte: be=0001<<addr[1:0], wdata = byte replicated x4.
- 01 is half: be=0011<<{addr[1],0}, wdata = half replicated x2.
- 1x is word: be=1111.
REQ-029 Load extension SHALL be: LB=000 and LH=001 sign-extend; LBU=100 and LHU=101 zero-extend; all other codes return the full word.
REQ-030 If ex_load and ex_store are both 1, the instruction SHALL be treated as a load.
REQ-031 All wb_* outputs SHALL be registered; wb_valid SHALL be high for exactly one cycle per accepted instruction.

Reset
REQ-032 With rst_n=0 at a clock edge, the next state SHALL be:
- FSM in IDLE;
- dmem_req, dmem_we, wb_valid, wb_regwrite and misalign at 0;
- dmem_be at 0000; dmem_addr, dmem_wdata, wb_data and wb_rd at 0.
REQ-033 Reset in REQ or WAIT SHALL abandon the transaction with no writeback; a later dmem_rvalid SHALL be ignored.

Configuration
REQ-034 Macro LSU_MISALIGN_TRAP_EN defined:
- Trigger: a half access with addr[0]=1, or a word access with addr[1:0]!=0.
- Response: no memory request; wb_valid next cycle with misalign=1 and wb_regwrite=0.
REQ-035 Macro undefined:
- misalign SHALL be constant 0.
- Offending low address bits SHALL be treated as 0 (half: addr[0]; word: addr[1:0]).

Verification
REQ-036 Non-memory: ex_addr=0x0000_1234, ex_regwrite=1, rd=5 -> next cycle wb_valid=1, wb_data=0x0000_1234, wb_rd=5.
REQ-037 SB: addr=0x103, wdata=0xAB -> dmem_addr=0x100, be=1000, wdata=0xABABABAB; gnt delayed 3 cycles -> outputs held stable, then one wb pulse with regwrite=0.
REQ-038 LB: addr=0x102, rdata=0x0080_0000, rvalid 2 cycles after gnt -> wb_data=0xFFFF_FF80; LBU on the same data -> 0x0000_0080.
REQ-039 Reset asserted in WAIT, then rvalid=1 -> no wb_valid, dmem_req=0, ex_ready=1.
REQ-040 LW at addr=0x006:
- LSU_MISALIGN_TRAP_EN defined -> misalign=1, dmem_req never asserted.
- Undefined -> dmem_addr=0x004, be=1111.
